// File: rtl/cdb_scheduler.sv
// Common data bus scheduler: one registered broadcast per cycle.
// Selection order: aged requester, high-priority round-robin, then low-priority round-robin.
module cdb_scheduler #(
  parameter int                 NUM_REQ   = 4,
  parameter int                 TAG_W     = 4,
  parameter int                 DATA_W    = 17,
  parameter logic [NUM_REQ-1:0] PRIO_MASK = 4'b1100,
  parameter int                 MAX_WAIT  = 7,
  localparam int                SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int                CNT_W     = $clog2(MAX_WAIT + 1)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*TAG_W-1:0]  tag_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic                      cdb_stall,
  output logic [NUM_REQ-1:0]        ack_out,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [NUM_REQ-1:0] r_ack;
  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_data;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_rr;
  logic [CNT_W-1:0]   r_wait [NUM_REQ];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_aged;
  logic [NUM_REQ-1:0] w_hi;
  logic [SRC_W-1:0]   w_win;
  logic               w_grant;

  // First set bit of m at or above p, wrapping modulo NUM_REQ.
  function automatic logic [SRC_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] m,
    input logic [SRC_W-1:0]   p
  );
    logic [SRC_W-1:0] res;
    int               idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (m[idx]) res = SRC_W'(idx);
    end
    return res;
  endfunction

  // Winner selection over the requesters not acknowledged this cycle.
  always_comb begin
    w_elig  = req_in & ~r_ack;
    w_aged  = '0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_aged[i] = w_elig[i] && (r_wait[i] == CNT_W'(MAX_WAIT));
    w_hi    = w_elig & PRIO_MASK;
    w_grant = (|w_elig) && !cdb_stall;
    if (|w_aged) begin
      for (int i = NUM_REQ - 1; i >= 0; i--)
        if (w_aged[i]) w_win = SRC_W'(i);
    end else if (|w_hi) begin
      w_win = rr_pick(w_hi, r_rr);
    end else begin
      w_win = rr_pick(w_elig, r_rr);
    end
  end

  // Registered grant, broadcast, round-robin pointer and aging counters.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_rr    <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
    end else begin
      if (w_grant) begin
        r_ack   <= NUM_REQ'(1) << w_win;
        r_valid <= 1'b1;
        r_tag   <= tag_in[int'(w_win)*TAG_W +: TAG_W];
        r_data  <= data_in[int'(w_win)*DATA_W +: DATA_W];
        r_src   <= w_win;
        r_rr    <= (w_win == SRC_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end else begin
        r_ack   <= '0;
        r_valid <= 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_in[i])
          r_wait[i] <= '0;
        else if (w_grant && w_win == SRC_W'(i))
          r_wait[i] <= '0;
        else if (w_elig[i] && r_wait[i] != CNT_W'(MAX_WAIT))
          r_wait[i] <= r_wait[i] + 1'b1;
      end
    end
  end

  assign ack_out   = r_ack;
  assign cdb_valid = r_valid;
  assign cdb_tag   = r_tag;
  assign cdb_data  = r_data;
  assign cdb_src   = r_src;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed bench for cdb_scheduler.
// Two instances: default priority mask and an all-low-priority mask.
module tb_cdb_scheduler;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  req_in;
  logic [15:0] tag_in;
  logic [67:0] data_in;
  logic        cdb_stall;

  logic [3:0]  hp_ack, rr_ack;
  logic        hp_valid, rr_valid;
  logic [3:0]  hp_tag, rr_tag;
  logic [16:0] hp_data, rr_data;
  logic [1:0]  hp_src, rr_src;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  cdb_scheduler u_hp (
    .clock(clock), .resetn(resetn), .req_in(req_in),
    .tag_in(tag_in), .data_in(data_in), .cdb_stall(cdb_stall),
    .ack_out(hp_ack), .cdb_valid(hp_valid), .cdb_tag(hp_tag),
    .cdb_data(hp_data), .cdb_src(hp_src)
  );

  cdb_scheduler #(.PRIO_MASK(4'b0000)) u_rr (
    .clock(clock), .resetn(resetn), .req_in(req_in),
    .tag_in(tag_in), .data_in(data_in), .cdb_stall(cdb_stall),
    .ack_out(rr_ack), .cdb_valid(rr_valid), .cdb_tag(rr_tag),
    .cdb_data(rr_data), .cdb_src(rr_src)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int i, input logic [3:0] t,
                     input logic [16:0] d);
    tag_in[i*4 +: 4]   = t;
    data_in[i*17 +: 17] = d;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_in    = '0;
    cdb_stall = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  int exp3 [8] = '{2, 3, 2, 3, 2, 3, 2, 0};
  int exp2 [5] = '{0, 1, 2, 3, 0};

  initial begin
    tag_in  = '0;
    data_in = '0;
    for (int i = 0; i < 4; i++) put(i, 4'(i + 1), 17'(17'h100 + i));

    // reset state
    do_reset();
    check("rst_ack", hp_ack, 0);
    check("rst_valid", hp_valid, 0);
    check("rst_tag", hp_tag, 0);
    check("rst_data", hp_data, 0);
    check("rst_src", hp_src, 0);

    // 1: single request
    put(2, 4'h5, 17'h1ABCD);
    req_in = 4'b0100;
    step();
    check("t1_ack", hp_ack, 4'b0100);
    check("t1_valid", hp_valid, 1);
    check("t1_tag", hp_tag, 5);
    check("t1_data", hp_data, 17'h1ABCD);
    check("t1_src", hp_src, 2);
    req_in = 4'b0000;
    step();
    check("t1_idle_valid", hp_valid, 0);
    check("t1_idle_ack", hp_ack, 0);
    check("t1_hold_tag", hp_tag, 5);
    check("t1_hold_src", hp_src, 2);
    put(2, 4'h3, 17'h102);

    // 2: round-robin, low class only
    do_reset();
    req_in = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_ack", rr_ack, 32'(1) << exp2[k]);
      check("t2_src", rr_src, exp2[k]);
      check("t2_tag", rr_tag, exp2[k] + 1);
      check("t2_valid", rr_valid, 1);
    end

    // 5: reset in the middle of the stream
    resetn = 1'b0;
    step();
    check("t5_ack", rr_ack, 0);
    check("t5_valid", rr_valid, 0);
    check("t5_tag", rr_tag, 0);
    check("t5_data", rr_data, 0);
    check("t5_src", rr_src, 0);
    resetn = 1'b1;
    step();
    check("t5_first", rr_ack, 4'b0001);

    // 3: priority plus aging
    do_reset();
    req_in = 4'b1101;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t3_ack", hp_ack, 32'(1) << exp3[k]);
      check("t3_src", hp_src, exp3[k]);
    end
    check("t3_data", hp_data, 17'h100);
    req_in = 4'b0000;

    // 4: stall keeps the pointer
    do_reset();
    req_in = 4'b0100;
    step();
    check("t4_pre", rr_ack, 4'b0100);
    req_in    = 4'b1011;
    cdb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_stall_ack", rr_ack, 0);
      check("t4_stall_valid", rr_valid, 0);
      check("t4_stall_tag", rr_tag, 3);
    end
    cdb_stall = 1'b0;
    step();
    check("t4_ack", rr_ack, 4'b1000);
    check("t4_src", rr_src, 3);
    check("t4_tag", rr_tag, 4);
    req_in = 4'b0000;

    // 6: same source back to back
    do_reset();
    req_in = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_ack", hp_ack, (k % 2 == 0) ? 4'b0010 : 4'b0000);
      check("t6_valid", hp_valid, (k % 2 == 0) ? 1 : 0);
    end
    req_in = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
